// File: rtl/parity_stream_encoder_pkg.sv
// Shared definitions for the parity stream encoder: parity mode encodings,
// the framing FSM state type and the default widths.
package parity_pkg;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 16;

  // IDLE: no beat of the current frame accepted yet.
  // MID : at least one beat accepted, closing beat not yet seen.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MID  = 1'b1
  } frame_state_e;

endpackage : parity_pkg

// File: rtl/parity_stream_encoder_if.sv
// Input and output stream of the parity encoder. The encoder sits on the
// slave modport; whoever feeds it and drains it uses the master modport.
interface parity_stream_encoder_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W:0]   m_data;
  logic              m_last;
  logic              m_frame_par;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_frame_par
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_frame_par
  );

endinterface : parity_stream_encoder_if

// File: rtl/parity_stream_encoder_reduce.sv
// XOR reduction of one payload word (1 = odd number of set bits).
module parity_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  output logic         par_o
);

  assign par_o = ^data_i;

endmodule : parity_reduce

// File: rtl/parity_stream_encoder.sv
// Single-register stream stage that appends a parity bit to each payload
// word, tracks frame boundaries, produces a running frame parity on the
// closing beat and counts accepted beats with saturation.
module parity_stream_encoder
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    odd_mode,
  parity_stream_encoder_if.slave  bus,
  output logic                    in_frame,
  output logic [CNT_W-1:0]        word_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  frame_state_e     state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [DATA_W:0]  m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             m_frame_par_q, m_frame_par_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s_ready_s;
  logic in_xfer_s;
  logic out_xfer_s;
  logic beat_par_s;
  logic odd_sel_s;

  parity_reduce #(.W(DATA_W)) u_reduce (
    .data_i (bus.s_data),
    .par_o  (beat_par_s)
  );

  // Stage can take a beat when empty or being drained this cycle; never in reset.
  assign s_ready_s  = !rst && (!m_valid_q || bus.m_ready);
  assign in_xfer_s  = bus.s_valid && s_ready_s;
  assign out_xfer_s = m_valid_q && bus.m_ready;
  assign odd_sel_s  = (odd_mode == PARITY_ODD);

  // Next-state logic for the output register, frame accumulator, counter and FSM.
  always_comb begin
    state_d       = state_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    m_frame_par_d = m_frame_par_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;

    if (in_xfer_s) begin
      m_valid_d = 1'b1;
      m_data_d  = {beat_par_s ^ odd_sel_s, bus.s_data};
      m_last_d  = bus.s_last;
      if (bus.s_last) begin
        m_frame_par_d = acc_q ^ beat_par_s ^ odd_sel_s;
        acc_d         = 1'b0;
      end else begin
        m_frame_par_d = 1'b0;
        acc_d         = acc_q ^ beat_par_s;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (out_xfer_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_xfer_s && !bus.s_last) begin
          state_d = ST_MID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MID: begin
        if (in_xfer_s && bus.s_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MID;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_frame_par_q <= 1'b0;
      acc_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      m_frame_par_q <= m_frame_par_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.s_ready     = s_ready_s;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_last      = m_last_q;
  assign bus.m_frame_par = m_frame_par_q;
  assign in_frame        = (state_q == ST_MID);
  assign word_count      = cnt_q;

endmodule : parity_stream_encoder

// File: tb/tb_parity_stream_encoder.sv
// Directed and randomized checks of parity_stream_encoder against a
// behavioural model built from bit counts, a pending-output queue and a
// per-frame beat list.
module tb_parity_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        odd_mode_a;
  logic        odd_mode_b;
  logic        in_frame_a;
  logic        in_frame_b;
  logic [15:0] word_count_a;
  logic [3:0]  word_count_b;

  int checks = 0;
  int errors = 0;

  parity_stream_encoder_if #(.DATA_W(8)) bus_a ();
  parity_stream_encoder_if #(.DATA_W(8)) bus_b ();

  parity_stream_encoder #(.DATA_W(8), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .odd_mode   (odd_mode_a),
    .bus        (bus_a.slave),
    .in_frame   (in_frame_a),
    .word_count (word_count_a)
  );

  parity_stream_encoder #(.DATA_W(8), .CNT_W(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .odd_mode   (odd_mode_b),
    .bus        (bus_b.slave),
    .in_frame   (in_frame_b),
    .word_count (word_count_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       last;
    logic       fp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Present one beat on stream A for a single edge (m_ready left as set).
  task automatic beat_a(input logic [7:0] d, input logic last, input logic odd);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = d;
    bus_a.s_last  = last;
    odd_mode_a    = odd;
    tick();
    bus_a.s_valid = 1'b0;
  endtask

  initial begin
    exp_t       e;
    logic       exp_rdy;
    int         ones;

    rst = 1'b1;
    odd_mode_a = 1'b0;  odd_mode_b = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_data = 8'h00; bus_a.s_last = 1'b0; bus_a.m_ready = 1'b1;
    bus_b.s_valid = 1'b0; bus_b.s_data = 8'h00; bus_b.s_last = 1'b0; bus_b.m_ready = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", 64'(bus_a.s_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_m_valid", 64'(bus_a.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus_a.m_data), 64'd0);
    chk("rst_word_count", 64'(word_count_a), 64'd0);
    chk("rst_in_frame", 64'(in_frame_a), 64'd0);
    chk("idle_s_ready", 64'(bus_a.s_ready), 64'd1);

    // Even parity of 0xA5 (four ones) and odd-mode single words.
    bus_a.m_ready = 1'b1;
    beat_a(8'hA5, 1'b1, 1'b0);
    chk("a5_m_valid", 64'(bus_a.m_valid), 64'd1);
    chk("a5_m_data", 64'(bus_a.m_data), 64'h0A5);
    beat_a(8'h00, 1'b1, 1'b1);
    chk("odd00_m_data", 64'(bus_a.m_data), 64'h100);
    beat_a(8'h01, 1'b1, 1'b1);
    chk("odd01_m_data", 64'(bus_a.m_data), 64'h001);
    tick();
    chk("drain_m_valid", 64'(bus_a.m_valid), 64'd0);

    // Backpressure: second beat must wait, then follow with no bubble or loss.
    do_reset();
    bus_a.m_ready = 1'b0;
    odd_mode_a = 1'b0;
    bus_a.s_valid = 1'b1; bus_a.s_data = 8'h11; bus_a.s_last = 1'b1;
    tick();
    bus_a.s_data = 8'h22;
    #1;
    chk("bp_s_ready", 64'(bus_a.s_ready), 64'd0);
    tick();
    chk("bp_hold_data", 64'(bus_a.m_data), 64'h011);
    chk("bp_word_count", 64'(word_count_a), 64'd1);
    bus_a.m_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus_a.s_ready), 64'd1);
    tick();
    bus_a.s_valid = 1'b0;
    chk("bp_next_data", 64'(bus_a.m_data), 64'h022);
    chk("bp_next_valid", 64'(bus_a.m_valid), 64'd1);
    chk("bp_word_count2", 64'(word_count_a), 64'd2);
    tick();
    chk("bp_empty", 64'(bus_a.m_valid), 64'd0);

    // Three-beat even frame 01,02,04: frame parity 1 on the closing beat.
    do_reset();
    beat_a(8'h01, 1'b0, 1'b0);
    chk("fr1_in_frame", 64'(in_frame_a), 64'd1);
    chk("fr1_m_data", 64'(bus_a.m_data), 64'h101);
    chk("fr1_fp", 64'(bus_a.m_frame_par), 64'd0);
    beat_a(8'h02, 1'b0, 1'b0);
    chk("fr2_m_last", 64'(bus_a.m_last), 64'd0);
    beat_a(8'h04, 1'b1, 1'b0);
    chk("fr3_m_data", 64'(bus_a.m_data), 64'h104);
    chk("fr3_m_last", 64'(bus_a.m_last), 64'd1);
    chk("fr3_fp", 64'(bus_a.m_frame_par), 64'd1);
    chk("fr3_in_frame", 64'(in_frame_a), 64'd0);

    // Narrow counter saturates after 15 beats.
    do_reset();
    bus_b.m_ready = 1'b1;
    bus_b.s_valid = 1'b1;
    bus_b.s_last  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_b.s_data = 8'(i);
      tick();
      if (i == 13) chk("sat_14", 64'(word_count_b), 64'hE);
    end
    chk("sat_17", 64'(word_count_b), 64'hF);
    tick(); tick(); tick();
    bus_b.s_valid = 1'b0;
    chk("sat_hold", 64'(word_count_b), 64'hF);

    // Reset mid-frame discards the partial frame and its accumulated parity.
    do_reset();
    beat_a(8'h01, 1'b0, 1'b0);
    beat_a(8'h00, 1'b0, 1'b0);
    chk("mid_in_frame", 64'(in_frame_a), 64'd1);
    rst = 1'b1;
    bus_a.s_valid = 1'b1; bus_a.s_data = 8'hFF; bus_a.s_last = 1'b0;
    tick();
    rst = 1'b0;
    bus_a.s_valid = 1'b0;
    chk("mrst_m_valid", 64'(bus_a.m_valid), 64'd0);
    chk("mrst_word_count", 64'(word_count_a), 64'd0);
    chk("mrst_in_frame", 64'(in_frame_a), 64'd0);
    beat_a(8'h03, 1'b1, 1'b0);
    chk("mrst_m_data", 64'(bus_a.m_data), 64'h003);
    chk("mrst_fp", 64'(bus_a.m_frame_par), 64'd0);
    chk("mrst_in_frame2", 64'(in_frame_a), 64'd0);

    // Randomized traffic against the queue/frame model.
    do_reset();
    exp_q.delete();
    frame_q.delete();
    accepted = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bus_a.s_valid = ($urandom_range(0, 3) != 0);
      bus_a.s_data  = 8'($urandom);
      bus_a.s_last  = ($urandom_range(0, 3) == 0);
      odd_mode_a    = 1'($urandom_range(0, 1));
      bus_a.m_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (exp_q.size() == 0) || bus_a.m_ready;
      chk("rnd_s_ready", 64'(bus_a.s_ready), 64'(exp_rdy));
      if (exp_q.size() != 0) begin
        chk("rnd_m_data", 64'(bus_a.m_data), 64'(exp_q[0].data));
        chk("rnd_m_last", 64'(bus_a.m_last), 64'(exp_q[0].last));
        chk("rnd_m_fp", 64'(bus_a.m_frame_par), 64'(exp_q[0].fp));
        if (bus_a.m_ready) void'(exp_q.pop_front());
      end
      if (bus_a.s_valid && exp_rdy) begin
        e.data = {1'(($countones(bus_a.s_data) % 2) ^ int'(odd_mode_a)), bus_a.s_data};
        e.last = bus_a.s_last;
        frame_q.push_back(bus_a.s_data);
        if (bus_a.s_last) begin
          ones = 0;
          foreach (frame_q[k]) ones += $countones(frame_q[k]);
          e.fp = 1'((ones % 2) ^ int'(odd_mode_a));
          frame_q.delete();
        end else begin
          e.fp = 1'b0;
        end
        exp_q.push_back(e);
        accepted++;
      end
      tick();
      chk("rnd_m_valid", 64'(bus_a.m_valid), 64'(exp_q.size() != 0));
      chk("rnd_in_frame", 64'(in_frame_a), 64'(frame_q.size() != 0));
      chk("rnd_word_count", 64'(word_count_a), 64'(accepted));
    end
    bus_a.s_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_parity_stream_encoder

// File: doc/parity_stream_encoder.md
PARITY_STREAM_ENCODER -- requirements
Module: parity_stream_encoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: payload width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the accepted-word counter, legal range 2..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port odd_mode, input, 1 bit: 0 selects even parity, 1 selects odd parity; sampled on each accepted beat.
REQ-006 The block SHALL have port s_valid, input, 1 bit: upstream beat valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: block can accept a beat.
REQ-008 The block SHALL have port s_data, input, DATA_W bits: payload.
REQ-009 The block SHALL have port s_last, input, 1 bit: beat closes the current frame.
REQ-010 The block SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream accepts the beat.
REQ-012 The block SHALL have port m_data, output, DATA_W+1 bits: {parity bit, payload}, parity in the MSB.
REQ-013 The block SHALL have port m_last, output, 1 bit: registered copy of s_last.
REQ-014 The block SHALL have port m_frame_par, output, 1 bit: frame parity, meaningful only while m_last=1.
REQ-015 The block SHALL have port in_frame, output, 1 bit: FSM is in state MID.
REQ-016 The block SHALL have port word_count, output, CNT_W bits: saturating count of accepted beats.

Function
REQ-017 An input transfer SHALL occur on a cycle where s_valid=1 and s_ready=1; an output transfer SHALL occur where m_valid=1 and m_ready=1.
REQ-018 s_ready SHALL equal (!m_valid || m_ready) when rst=0, and 0 when rst=1 (combinational).
REQ-019 On an input transfer, the output register SHALL load on the next edge: latency 1 cycle; m_valid SHALL then be 1.
REQ-020 m_data[DATA_W] SHALL equal XOR of all s_data bits XOR odd_mode; m_data[DATA_W-1:0] SHALL equal s_data.
REQ-021 m_valid SHALL clear after an output transfer with no simultaneous input transfer; simultaneous input and output transfers SHALL reload the register with no bubble.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_last and m_frame_par SHALL hold stable.
REQ-023 The FSM SHALL have states IDLE (no beat of the current frame accepted) and MID (at least one beat accepted, last not yet seen).
REQ-024 Transitions: IDLE->MID on a transfer with s_last=0; MID->IDLE on a transfer with s_last=1; all other cases hold the state.
REQ-025 A single-beat frame (s_last=1 in IDLE) SHALL stay in IDLE.
REQ-026 A frame accumulator SHALL XOR in the data parity of each accepted beat, and SHALL clear to 0 on the edge that accepts the s_last=1 beat.
REQ-027 On a beat with s_last=1, m_frame_par SHALL equal (accumulator XOR beat data parity XOR odd_mode at that beat); otherwise m_frame_par SHALL be 0.
REQ-028 word_count SHALL increment by 1 per input transfer and SHALL saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-029 With rst=1 at an edge: m_valid, m_data, m_last, m_frame_par, the accumulator and word_count SHALL be 0, and the FSM SHALL be IDLE.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the next accepted beat SHALL start a new frame.
REQ-031 Inputs SHALL be ignored during any cycle with rst=1.

Structure
REQ-032 Package parity_pkg SHALL hold PARITY_EVEN=1'b0, PARITY_ODD=1'b1, the FSM state enum, and the default DATA_W and CNT_W.
REQ-033 Sub-module parity_reduce (parameter W; input W bits, output 1-bit XOR reduction) SHALL compute the beat parity.

Verification (DATA_W=8 unless noted)
REQ-034 Even mode, s_data=8'hA5, m_ready=1 -> next cycle m_valid=1, m_data=9'h0A5.
REQ-035 Odd mode, s_data=8'h00 -> m_data=9'h100; odd mode, 8'h01 -> m_data=9'h001.
REQ-036 Backpressure: m_ready=0, s_valid held with beats 8'h11 then 8'h22 -> m_data stays 9'h011, s_ready=0, word_count=1; after m_ready=1, 8'h22 follows with no loss or duplication.
REQ-037 Even-mode frame 8'h01, 8'h02, 8'h04 (last on 3rd) -> in_frame=1 after the 1st beat; 3rd output has m_last=1, m_frame_par=1; in_frame=0 afterwards.
REQ-038 CNT_W=4, 17 back-to-back beats -> word_count=4'hF and stays there.
REQ-039 Two beats of a frame, then rst for 1 cycle, then single beat 8'h03 with last -> m_valid=0 and word_count=0 after reset; then m_frame_par=0 and in_frame=0.
